// File: rtl/pong_pkg.sv
// Shared encodings and screen constants for the pong command scheduler.
package pong_pkg;

  localparam logic [1:0] OP_MOVE     = 2'b00;
  localparam logic [1:0] OP_START    = 2'b01;
  localparam logic [1:0] OP_PAUSE    = 2'b10;
  localparam logic [1:0] OP_CLR_DROP = 2'b11;

  typedef enum logic [1:0] {
    ST_MENU  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } game_state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int Y_MAX      = 479;
  localparam int BAR_H      = 60;
  localparam int Y_INIT     = 210;
  localparam int WIN_SCORE  = 3;

  typedef struct packed {
    logic       sel;
    logic [8:0] y;
  } move_t;

  function automatic logic [8:0] clamp_y(input logic [8:0] y, input logic [8:0] lim);
    return (y > lim) ? lim : y;
  endfunction

endpackage

// File: rtl/pong_update_sched_if.sv
// Command port from the Nios custom instruction: one-cycle valid strobe, 32-bit word, ready.
interface pong_update_sched_if;

  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);

endinterface

// File: rtl/pong_cmd_fifo.sv
// Synchronous FIFO with flush; push on full and pop on empty are ignored, flush beats both.
module pong_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pong_update_sched.sv
// Game FSM plus paddle-move scheduler that applies moves only in vblank (1-cycle pop->bar latency).
// PONG_SCHED_COALESCE_EN swaps the move FIFO for one pending register per bar.
module pong_update_sched #(
  parameter int FIFO_DEPTH = pong_pkg::FIFO_DEPTH,
  parameter int Y_MAX      = pong_pkg::Y_MAX,
  parameter int BAR_H      = pong_pkg::BAR_H,
  parameter int Y_INIT     = pong_pkg::Y_INIT,
  parameter int WIN_SCORE  = pong_pkg::WIN_SCORE
) (
  input  logic                      CLK,
  input  logic                      resentinho,
  pong_update_sched_if.slave        cmd,
  input  logic                      vblank,
  input  logic [3:0]                score,
  output logic                      enable_game,
  output logic [1:0]                game_state,
  output logic [8:0]                bar1_y,
  output logic [8:0]                bar2_y,
  output logic                      refresh_bar1,
  output logic                      refresh_bar2,
  output logic [7:0]                drop_cnt
);

  import pong_pkg::*;

  localparam logic [8:0] Y_LIM   = 9'(Y_MAX + 1 - BAR_H);
  localparam logic [8:0] Y_START = 9'(Y_INIT);
  localparam logic [1:0] WIN     = 2'(WIN_SCORE);

  game_state_t state;
  game_state_t state_nxt;
  logic [1:0]  op;
  move_t       cmd_move;
  logic        accept;
  logic        lost;
  logic        win;
  logic        in_game;
  logic        do_start;
  logic        do_pause;
  logic        do_move;
  logic        do_clr;
  logic        flush;
  logic        drain_en;
  logic        apply_vld;
  move_t       apply;
  logic        unused_cmd_bits;

  assign op              = cmd.cmd_data[11:10];
  assign cmd_move        = move_t'(cmd.cmd_data[9:0]);
  assign unused_cmd_bits = ^cmd.cmd_data[31:12];

  assign accept  = cmd.cmd_valid & cmd.cmd_ready;
  assign lost    = cmd.cmd_valid & ~cmd.cmd_ready;
  assign in_game = (state == ST_PLAY) || (state == ST_PAUSE);
  assign win     = (state == ST_PLAY) && ((score[1:0] == WIN) || (score[3:2] == WIN));

  // A winning score swallows whatever command arrives in the same cycle.
  assign do_start = accept & ~win & (op == OP_START) & ~in_game;
  assign do_pause = accept & ~win & (op == OP_PAUSE) & in_game;
  assign do_move  = accept & ~win & (op == OP_MOVE) & in_game;
  assign do_clr   = accept & ~win & (op == OP_CLR_DROP);
  assign flush    = do_start | win;
  assign drain_en = (state == ST_PLAY) & vblank & ~win;

  always_ff @(posedge CLK) begin
    if (!resentinho) state <= ST_MENU;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (win) begin
      state_nxt = ST_OVER;
    end else if (do_start) begin
      state_nxt = ST_PLAY;
    end else if (do_pause) begin
      state_nxt = (state == ST_PLAY) ? ST_PAUSE : ST_PLAY;
    end
  end

`ifdef PONG_SCHED_COALESCE_EN
  logic       pend1_vld;
  logic       pend2_vld;
  logic [8:0] pend1_y;
  logic [8:0] pend2_y;

  assign cmd.cmd_ready = 1'b1;

  always_comb begin
    apply_vld = 1'b0;
    apply     = '0;
    if (drain_en && pend1_vld) begin
      apply_vld = 1'b1;
      apply.sel = 1'b0;
      apply.y   = pend1_y;
    end else if (drain_en && pend2_vld) begin
      apply_vld = 1'b1;
      apply.sel = 1'b1;
      apply.y   = pend2_y;
    end
  end

  // A move landing in the same cycle its bar drains keeps the slot pending with the newer Y.
  always_ff @(posedge CLK) begin
    if (!resentinho || flush) begin
      pend1_vld <= 1'b0;
      pend2_vld <= 1'b0;
      pend1_y   <= '0;
      pend2_y   <= '0;
    end else begin
      if (apply_vld && !apply.sel) pend1_vld <= 1'b0;
      if (apply_vld &&  apply.sel) pend2_vld <= 1'b0;
      if (do_move && !cmd_move.sel) begin
        pend1_vld <= 1'b1;
        pend1_y   <= cmd_move.y;
      end
      if (do_move && cmd_move.sel) begin
        pend2_vld <= 1'b1;
        pend2_y   <= cmd_move.y;
      end
    end
  end
`else
  logic       fifo_full;
  logic       fifo_empty;
  logic [9:0] fifo_rdata;

  pong_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (10)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (resentinho),
    .push  (do_move),
    .pop   (apply_vld),
    .flush (flush),
    .wdata (cmd_move),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd.cmd_ready = ~fifo_full;
  assign apply_vld     = drain_en & ~fifo_empty;
  assign apply         = move_t'(fifo_rdata);
`endif

  always_ff @(posedge CLK) begin
    if (!resentinho) begin
      bar1_y       <= Y_START;
      bar2_y       <= Y_START;
      refresh_bar1 <= 1'b0;
      refresh_bar2 <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      refresh_bar1 <= 1'b0;
      refresh_bar2 <= 1'b0;
      if (do_start) begin
        bar1_y <= Y_START;
        bar2_y <= Y_START;
      end else if (apply_vld) begin
        if (apply.sel) begin
          bar2_y       <= clamp_y(apply.y, Y_LIM);
          refresh_bar2 <= 1'b1;
        end else begin
          bar1_y       <= clamp_y(apply.y, Y_LIM);
          refresh_bar1 <= 1'b1;
        end
      end
      if (do_clr) begin
        drop_cnt <= '0;
      end else if (lost && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign enable_game = (state == ST_PLAY);
  assign game_state  = state;

endmodule

// File: tb/tb_pong_update_sched.sv
// Randomised and directed bench for pong_update_sched against a queue-based game model.
module tb_pong_update_sched;

  localparam int DEPTH = 4;
  localparam logic [1:0] C_MOVE  = 2'b00;
  localparam logic [1:0] C_START = 2'b01;
  localparam logic [1:0] C_PAUSE = 2'b10;
  localparam logic [1:0] C_CLR   = 2'b11;

  logic       CLK = 1'b0;
  logic       resentinho;
  logic       vblank;
  logic [3:0] score;
  logic       enable_game;
  logic [1:0] game_state;
  logic [8:0] bar1_y;
  logic [8:0] bar2_y;
  logic       refresh_bar1;
  logic       refresh_bar2;
  logic [7:0] drop_cnt;

  pong_update_sched_if cmd_if ();

  pong_update_sched dut (
    .CLK          (CLK),
    .resentinho   (resentinho),
    .cmd          (cmd_if),
    .vblank       (vblank),
    .score        (score),
    .enable_game  (enable_game),
    .game_state   (game_state),
    .bar1_y       (bar1_y),
    .bar2_y       (bar2_y),
    .refresh_bar1 (refresh_bar1),
    .refresh_bar2 (refresh_bar2),
    .drop_cnt     (drop_cnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference game: state 0 MENU, 1 PLAY, 2 PAUSE, 3 OVER; queue of {sel, y}.
  int         m_state = 0;
  int         m_b1 = 210;
  int         m_b2 = 210;
  int         m_drop = 0;
  bit         m_r1 = 0;
  bit         m_r2 = 0;
  logic [9:0] m_q[$];

  task automatic model_step();
    logic [1:0] op;
    logic [9:0] e;
    int         y;
    bit         ready;
    bit         win;
    if (!resentinho) begin
      m_state = 0; m_b1 = 210; m_b2 = 210; m_r1 = 0; m_r2 = 0; m_drop = 0;
      m_q.delete();
      return;
    end
    op    = cmd_if.cmd_data[11:10];
    ready = (m_q.size() < DEPTH);
    win   = (m_state == 1) && (score[1:0] == 2'd3 || score[3:2] == 2'd3);
    m_r1 = 0;
    m_r2 = 0;
    if (cmd_if.cmd_valid && !ready && m_drop < 255) m_drop++;
    if (win) begin
      m_state = 3;
      m_q.delete();
    end else begin
      if (m_state == 1 && vblank && m_q.size() > 0) begin
        e = m_q.pop_front();
        y = (int'(e[8:0]) > 420) ? 420 : int'(e[8:0]);
        if (e[9]) begin m_b2 = y; m_r2 = 1; end
        else      begin m_b1 = y; m_r1 = 1; end
      end
      if (cmd_if.cmd_valid && ready) begin
        case (op)
          C_MOVE:  if (m_state == 1 || m_state == 2) m_q.push_back(cmd_if.cmd_data[9:0]);
          C_START: if (m_state == 0 || m_state == 3) begin
                     m_state = 1; m_b1 = 210; m_b2 = 210; m_q.delete();
                   end
          C_PAUSE: if (m_state == 1) m_state = 2; else if (m_state == 2) m_state = 1;
          default: m_drop = 0;
        endcase
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic sel, input logic [8:0] y);
    logic [31:0] d;
    d = $urandom();
    d[11:0] = {op, sel, y};
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_data  = d;
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    resentinho = 1'b0; vblank = 1'b0; score = 4'd0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_data = '0;
    tick(); tick();
    checks++;
    if ({game_state, enable_game} !== 3'b000) begin
      errors++; $display("FAIL reset_state: got st=%0d en=%0d, want st=0 en=0", game_state, enable_game);
    end
    checks++;
    if (bar1_y !== 9'd210 || bar2_y !== 9'd210) begin
      errors++; $display("FAIL reset_bars: got %0d/%0d, want 210/210", bar1_y, bar2_y);
    end
    checks++;
    if ({refresh_bar1, refresh_bar2, cmd_if.cmd_ready} !== 3'b001 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_misc: got r=%b%b rdy=%b drop=%0d, want r=00 rdy=1 drop=0",
                         refresh_bar1, refresh_bar2, cmd_if.cmd_ready, drop_cnt);
    end
    resentinho = 1'b1;
  endtask

  task automatic test_start();
    send(C_START, 1'b0, 9'd0);
    checks++;
    if (game_state !== 2'b01 || enable_game !== 1'b1 || bar1_y !== 9'd210 || bar2_y !== 9'd210) begin
      errors++; $display("FAIL start: got st=%0d en=%0d bars=%0d/%0d, want st=1 en=1 bars=210/210",
                         game_state, enable_game, bar1_y, bar2_y);
    end
  endtask

  task automatic test_move_vblank();
    int strobes;
    vblank = 1'b0;
    send(C_MOVE, 1'b0, 9'd100);
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      strobes += int'(refresh_bar1) + int'(refresh_bar2);
    end
    checks++;
    if (strobes != 0 || bar1_y !== 9'd210) begin
      errors++; $display("FAIL move_no_vblank: got strobes=%0d bar1=%0d, want 0 and 210", strobes, bar1_y);
    end
    vblank = 1'b1;
    tick();
    checks++;
    if (refresh_bar1 !== 1'b1 || refresh_bar2 !== 1'b0 || bar1_y !== 9'd100) begin
      errors++; $display("FAIL move_apply: got r1=%b r2=%b bar1=%0d, want 1 0 100", refresh_bar1, refresh_bar2, bar1_y);
    end
    tick();
    checks++;
    if (refresh_bar1 !== 1'b0) begin
      errors++; $display("FAIL move_strobe_width: got r1=%b, want 0", refresh_bar1);
    end
    vblank = 1'b0;
  endtask

  task automatic test_clamp();
    vblank = 1'b1;
    send(C_MOVE, 1'b1, 9'd470);
    tick();
    checks++;
    if (bar2_y !== 9'd420 || refresh_bar2 !== 1'b1 || refresh_bar1 !== 1'b0) begin
      errors++; $display("FAIL clamp: got bar2=%0d r2=%b r1=%b, want 420 1 0", bar2_y, refresh_bar2, refresh_bar1);
    end
    vblank = 1'b0;
  endtask

  task automatic test_overflow();
    vblank = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(C_MOVE, i[0], 9'(50 + 10 * i));
      if (i == 3) begin
        checks++;
        if (cmd_if.cmd_ready !== 1'b0) begin
          errors++; $display("FAIL full_ready: got %b, want 0", cmd_if.cmd_ready);
        end
      end
    end
    checks++;
    if (drop_cnt !== 8'd1) begin
      errors++; $display("FAIL overflow_drop: got %0d, want 1", drop_cnt);
    end
    vblank = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (i[0] == 1'b0) begin
        if (refresh_bar1 !== 1'b1 || refresh_bar2 !== 1'b0 || bar1_y !== 9'(50 + 10 * i)) begin
          errors++; $display("FAIL drain_order %0d: got r=%b%b bar1=%0d, want r=10 bar1=%0d",
                             i, refresh_bar1, refresh_bar2, bar1_y, 50 + 10 * i);
        end
      end else if (refresh_bar2 !== 1'b1 || refresh_bar1 !== 1'b0 || bar2_y !== 9'(50 + 10 * i)) begin
        errors++; $display("FAIL drain_order %0d: got r=%b%b bar2=%0d, want r=01 bar2=%0d",
                           i, refresh_bar1, refresh_bar2, bar2_y, 50 + 10 * i);
      end
    end
    vblank = 1'b0;
    send(C_CLR, 1'b0, 9'd0);
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++; $display("FAIL clr_drop: got %0d, want 0", drop_cnt);
    end
  endtask

  task automatic test_pause();
    int strobes;
    vblank = 1'b0;
    send(C_MOVE, 1'b0, 9'd300);
    send(C_MOVE, 1'b1, 9'd400);
    send(C_PAUSE, 1'b0, 9'd0);
    checks++;
    if (game_state !== 2'b10 || enable_game !== 1'b0) begin
      errors++; $display("FAIL pause_enter: got st=%0d en=%0d, want 2 0", game_state, enable_game);
    end
    vblank = 1'b1;
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      strobes += int'(refresh_bar1) + int'(refresh_bar2);
    end
    send(C_PAUSE, 1'b0, 9'd0);
    strobes += int'(refresh_bar1) + int'(refresh_bar2);
    checks++;
    if (strobes != 0 || game_state !== 2'b01) begin
      errors++; $display("FAIL pause_hold: got strobes=%0d st=%0d, want 0 and 1", strobes, game_state);
    end
    tick();
    checks++;
    if (refresh_bar1 !== 1'b1 || bar1_y !== 9'd300) begin
      errors++; $display("FAIL resume_first: got r1=%b bar1=%0d, want 1 300", refresh_bar1, bar1_y);
    end
    tick();
    checks++;
    if (refresh_bar2 !== 1'b1 || refresh_bar1 !== 1'b0 || bar2_y !== 9'd400) begin
      errors++; $display("FAIL resume_second: got r=%b%b bar2=%0d, want r=01 400", refresh_bar1, refresh_bar2, bar2_y);
    end
    vblank = 1'b0;
  endtask

  task automatic test_win();
    int strobes;
    vblank = 1'b0;
    for (int i = 0; i < 4; i++) send(C_MOVE, 1'b1, 9'(20 * i));
    score = 4'b0011;
    tick();
    score = 4'b0000;
    checks++;
    if (game_state !== 2'b11 || enable_game !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL win_p1: got st=%0d en=%0d rdy=%b, want 3 0 1", game_state, enable_game, cmd_if.cmd_ready);
    end
    send(C_MOVE, 1'b0, 9'd5);
    send(C_PAUSE, 1'b0, 9'd0);
    checks++;
    if (drop_cnt !== 8'd0 || game_state !== 2'b11) begin
      errors++; $display("FAIL over_ignore: got drop=%0d st=%0d, want 0 3", drop_cnt, game_state);
    end
    send(C_START, 1'b0, 9'd0);
    vblank = 1'b1;
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      strobes += int'(refresh_bar1) + int'(refresh_bar2);
    end
    checks++;
    if (strobes != 0 || game_state !== 2'b01 || bar1_y !== 9'd210) begin
      errors++; $display("FAIL win_flush: got strobes=%0d st=%0d bar1=%0d, want 0 1 210", strobes, game_state, bar1_y);
    end
    score = 4'b1100;
    tick();
    score = 4'b0000;
    checks++;
    if (game_state !== 2'b11) begin
      errors++; $display("FAIL win_p2: got st=%0d, want 3", game_state);
    end
    vblank = 1'b0;
    send(C_START, 1'b0, 9'd0);
  endtask

  task automatic test_reset_mid_drain();
    int strobes;
    vblank = 1'b0;
    send(C_MOVE, 1'b0, 9'd10);
    send(C_MOVE, 1'b1, 9'd20);
    send(C_MOVE, 1'b0, 9'd30);
    vblank = 1'b1;
    tick();
    resentinho = 1'b0;
    tick();
    checks++;
    if (game_state !== 2'b00 || enable_game !== 1'b0 || bar1_y !== 9'd210 || bar2_y !== 9'd210 ||
        refresh_bar1 !== 1'b0 || refresh_bar2 !== 1'b0 || cmd_if.cmd_ready !== 1'b1 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_mid_drain: got st=%0d en=%0d bars=%0d/%0d r=%b%b rdy=%b drop=%0d",
                         game_state, enable_game, bar1_y, bar2_y, refresh_bar1, refresh_bar2,
                         cmd_if.cmd_ready, drop_cnt);
    end
    resentinho = 1'b1;
    send(C_START, 1'b0, 9'd0);
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      strobes += int'(refresh_bar1) + int'(refresh_bar2);
    end
    checks++;
    if (strobes != 0) begin
      errors++; $display("FAIL reset_discard: got %0d strobes, want 0", strobes);
    end
    vblank = 1'b0;
  endtask

  task automatic test_saturate();
    vblank = 1'b0;
    for (int i = 0; i < 264; i++) send(C_MOVE, 1'b0, 9'd77);
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++; $display("FAIL drop_saturate: got %0d, want 255", drop_cnt);
    end
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    send(C_CLR, 1'b0, 9'd0);
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++; $display("FAIL clr_after_sat: got %0d, want 0", drop_cnt);
    end
    vblank = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    vblank = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] act;
    logic [31:0] exp;
    int          r;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      resentinho = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 7) == 0) vblank = ~vblank;
      cmd_if.cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_if.cmd_data  = $urandom();
      r = $urandom_range(0, 19);
      cmd_if.cmd_data[11:10] = (r < 14) ? C_MOVE : (r < 16) ? C_PAUSE : (r < 18) ? C_START : C_CLR;
      tick();
      act = {game_state, enable_game, bar1_y, bar2_y, refresh_bar1, refresh_bar2, drop_cnt, cmd_if.cmd_ready};
      exp = {2'(m_state), (m_state == 1), 9'(m_b1), 9'(m_b2), m_r1, m_r2, 8'(m_drop), (m_q.size() < DEPTH)};
      checks++;
      if (act !== exp) begin
        errors++; $display("FAIL random cyc %0d: got %h, want %h", cyc, act, exp);
      end
      checks++;
      if (refresh_bar1 === 1'b1 && refresh_bar2 === 1'b1) begin
        errors++; $display("FAIL refresh_exclusive cyc %0d: got both strobes high, want at most one", cyc);
      end
    end
    resentinho = 1'b1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_move_vblank();
    test_clamp();
    test_overflow();
    test_pause();
    test_win();
    test_reset_mid_drain();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
